// File: rtl/alu_wide.sv
// Multi-cycle wide ALU: processes one 8-bit slice per clock, chaining carry or
// shifted-out bits between slices, and publishes result and flags together on done.
module alu_wide #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic             inv_b,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow_out,
    output logic             zero_out,
    output logic             neg_out,
    output logic [1:0]       dbg_state
);

    localparam int SLICES = WIDTH / 8;

    localparam logic [2:0] OP_SUM = 3'd0;
    localparam logic [2:0] OP_AND = 3'd1;
    localparam logic [2:0] OP_EOR = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_SR  = 3'd4;
    localparam logic [2:0] OP_ROR = 3'd5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t state, state_next;

    logic [2:0]       op_r;
    logic             inv_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             cin_r;
    logic [2:0]       cnt;
    logic             chain_r;
    logic [WIDTH-1:0] acc_r;

    logic             last_slice;
    logic             msb_first;
    logic [2:0]       slice_idx;
    logic [5:0]       slice_sh;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] a_shift;
    logic [WIDTH-1:0] b_shift;
    logic [7:0]       a_sl;
    logic [7:0]       b_sl;
    logic [8:0]       sum9;
    logic [7:0]       slice_out;
    logic             chain_next;
    logic [WIDTH-1:0] acc_next;
    logic             fin_carry;
    logic             fin_ovf;

    // Handshake: a request is taken on any rising edge where start=1 and busy=0;
    // busy stays high until the done cycle, during which a new start is accepted.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN: begin
                busy = 1'b1;
                if (last_slice) state_next = FINISH;
            end
            FINISH: begin
                busy       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign dbg_state  = state;
    assign last_slice = (cnt == 3'(SLICES - 1));

    // Shifts walk from the top slice down so the shifted-out bit feeds the next lower slice.
    assign msb_first = (op_r == OP_SR) || (op_r == OP_ROR);
    assign slice_idx = msb_first ? (3'(SLICES - 1) - cnt) : cnt;
    assign slice_sh  = {slice_idx, 3'b000};
    assign b_eff     = inv_r ? ~b_r : b_r;
    assign a_shift   = a_r >> slice_sh;
    assign b_shift   = b_eff >> slice_sh;
    assign a_sl      = a_shift[7:0];
    assign b_sl      = b_shift[7:0];
    assign sum9      = {1'b0, a_sl} + {1'b0, b_sl} + {8'd0, chain_r};

    always_comb begin
        slice_out  = 8'd0;
        chain_next = chain_r;
        case (op_r)
            OP_SUM: begin
                slice_out  = sum9[7:0];
                chain_next = sum9[8];
            end
            OP_AND: slice_out = a_sl & b_sl;
            OP_EOR: slice_out = a_sl ^ b_sl;
            OP_OR:  slice_out = a_sl | b_sl;
            OP_SR, OP_ROR: begin
                slice_out  = {chain_r, a_sl[7:1]};
                chain_next = a_sl[0];
            end
            default: slice_out = 8'd0;
        endcase
    end

    assign acc_next = (acc_r & ~(WIDTH'(8'hFF) << slice_sh)) | (WIDTH'(slice_out) << slice_sh);

    always_comb begin
        fin_carry = cin_r;
        fin_ovf   = 1'b0;
        case (op_r)
            OP_SUM: begin
                fin_carry = chain_r;
                fin_ovf   = (a_r[WIDTH-1] == b_eff[WIDTH-1]) && (acc_r[WIDTH-1] != a_r[WIDTH-1]);
            end
            OP_SR, OP_ROR: fin_carry = chain_r;
            default: fin_carry = cin_r;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            op_r         <= 3'd0;
            inv_r        <= 1'b0;
            a_r          <= '0;
            b_r          <= '0;
            cin_r        <= 1'b0;
            cnt          <= 3'd0;
            chain_r      <= 1'b0;
            acc_r        <= '0;
            done         <= 1'b0;
            result       <= '0;
            carry_out    <= 1'b0;
            overflow_out <= 1'b0;
            zero_out     <= 1'b1;
            neg_out      <= 1'b0;
        end else begin
            state <= state_next;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_r    <= op;
                        inv_r   <= inv_b;
                        a_r     <= a_in;
                        b_r     <= b_in;
                        cin_r   <= carry_in;
                        cnt     <= 3'd0;
                        acc_r   <= '0;
                        chain_r <= (op == OP_SR) ? 1'b0 : carry_in;
                    end
                end
                RUN: begin
                    acc_r   <= acc_next;
                    chain_r <= chain_next;
                    cnt     <= cnt + 3'd1;
                end
                FINISH: begin
                    done         <= 1'b1;
                    result       <= acc_r;
                    carry_out    <= fin_carry;
                    overflow_out <= fin_ovf;
                    zero_out     <= (acc_r == '0);
                    neg_out      <= acc_r[WIDTH-1];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_wide.sv
// Self-checking bench for alu_wide at WIDTH=16: directed cases plus random ops
// compared against an arithmetic reference model.
module tb_alu_wide;

    localparam int WIDTH  = 16;
    localparam int SLICES = WIDTH / 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [2:0]       op;
    logic             inv_b;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             carry_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow_out;
    logic             zero_out;
    logic             neg_out;
    logic [1:0]       dbg_state;

    int errors = 0;
    int checks = 0;
    logic [WIDTH-1:0] last_res;

    typedef struct packed {
        logic [WIDTH-1:0] r;
        logic             c;
        logic             v;
        logic             z;
        logic             n;
    } exp_t;

    alu_wide #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .inv_b(inv_b),
        .a_in(a_in), .b_in(b_in), .carry_in(carry_in),
        .busy(busy), .done(done), .result(result), .carry_out(carry_out),
        .overflow_out(overflow_out), .zero_out(zero_out), .neg_out(neg_out),
        .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [2:0] o, input logic inv, input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b, input logic cin);
        exp_t e;
        logic [WIDTH-1:0] bb;
        logic [WIDTH:0]   s;
        bb  = inv ? ~b : b;
        e.c = cin;
        e.v = 1'b0;
        case (o)
            3'd0: begin
                s   = {1'b0, a} + {1'b0, bb} + (WIDTH+1)'(cin);
                e.r = s[WIDTH-1:0];
                e.c = s[WIDTH];
                e.v = (a[WIDTH-1] == bb[WIDTH-1]) && (e.r[WIDTH-1] != a[WIDTH-1]);
            end
            3'd1: e.r = a & bb;
            3'd2: e.r = a ^ bb;
            3'd3: e.r = a | bb;
            3'd4: begin e.r = a >> 1;               e.c = a[0]; end
            3'd5: begin e.r = {cin, a[WIDTH-1:1]};  e.c = a[0]; end
            default: e.r = '0;
        endcase
        e.z = (e.r == '0);
        e.n = e.r[WIDTH-1];
        return e;
    endfunction

    task automatic run_op(input logic [2:0] op_v, input logic inv_v, input logic [WIDTH-1:0] a_v,
                          input logic [WIDTH-1:0] b_v, input logic cin_v, input bit pulse);
        exp_t e;
        int   k;
        bit   seen;
        e = model(op_v, inv_v, a_v, b_v, cin_v);
        @(negedge clk);
        start = 1'b1; op = op_v; inv_b = inv_v; a_in = a_v; b_in = b_v; carry_in = cin_v;
        @(posedge clk); #1;
        start = 1'b0;
        op = 3'($urandom); inv_b = 1'($urandom); a_in = WIDTH'($urandom);
        b_in = WIDTH'($urandom); carry_in = 1'($urandom);
        chk("accept_busy", busy, 1);
        chk("accept_done_low", done, 0);
        seen = 0;
        k    = 0;
        while (!seen && k < 10) begin
            if (pulse && k == 1) begin
                start = 1'b1; a_in = WIDTH'($urandom); b_in = WIDTH'($urandom);
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            k++;
            if (done) seen = 1;
            else chk("hold_result", result, last_res);
        end
        start = 1'b0;
        chk("done_seen", seen, 1);
        chk("latency", k, SLICES + 1);
        chk("done_busy_low", busy, 0);
        chk("result", result, e.r);
        chk("carry", carry_out, e.c);
        chk("overflow", overflow_out, e.v);
        chk("zero", zero_out, e.z);
        chk("neg", neg_out, e.n);
        last_res = e.r;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 3'd0; inv_b = 1'b0;
        a_in = '0; b_in = '0; carry_in = 1'b0;
        last_res = '0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_carry", carry_out, 0);
        chk("rst_ovf", overflow_out, 0);
        chk("rst_zero", zero_out, 1);
        chk("rst_neg", neg_out, 0);
        @(negedge clk); rst = 1'b0;

        run_op(3'd0, 1'b0, 16'h00FF, 16'h0001, 1'b0, 0);
        chk("sum_ff_1", result, 16'h0100);
        run_op(3'd0, 1'b0, 16'h7FFF, 16'h0001, 1'b0, 0);
        chk("sum_ovf_res", result, 16'h8000);
        chk("sum_ovf_flag", overflow_out, 1);
        run_op(3'd0, 1'b0, 16'hFFFF, 16'h0001, 1'b0, 0);
        chk("sum_wrap_carry", carry_out, 1);
        chk("sum_wrap_zero", zero_out, 1);
        run_op(3'd0, 1'b1, 16'h0000, 16'h0001, 1'b1, 0);
        chk("sub_neg_res", result, 16'hFFFF);
        chk("sub_neg_carry", carry_out, 0);
        run_op(3'd0, 1'b1, 16'h000F, 16'h000C, 1'b1, 0);
        chk("sub_pos_res", result, 16'h0003);
        chk("sub_pos_carry", carry_out, 1);
        run_op(3'd4, 1'b0, 16'hF001, 16'h0000, 1'b0, 0);
        chk("sr_res", result, 16'h7800);
        chk("sr_carry", carry_out, 1);
        run_op(3'd5, 1'b0, 16'h0001, 16'h0000, 1'b1, 0);
        chk("ror_res", result, 16'h8000);
        chk("ror_carry", carry_out, 1);
        run_op(3'd2, 1'b0, 16'hF0F0, 16'hAAAA, 1'b0, 0);
        chk("eor_res", result, 16'h5A5A);
        run_op(3'd6, 1'b0, 16'h1234, 16'h5678, 1'b1, 0);
        chk("reserved_zero", zero_out, 1);
        run_op(3'd0, 1'b0, 16'h0102, 16'h0304, 1'b0, 1);
        chk("busy_ignored", result, 16'h0406);
        run_op(3'd3, 1'b0, 16'h1200, 16'h0034, 1'b0, 0);
        chk("back_to_back", result, 16'h1234);

        @(negedge clk);
        start = 1'b1; op = 3'd0; a_in = 16'hAAAA; b_in = 16'h5555; carry_in = 1'b0; inv_b = 1'b0;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1; #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_result", result, 0);
        chk("mid_rst_zero", zero_out, 1);
        chk("mid_rst_carry", carry_out, 0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("mid_rst_no_done", done, 0);
        end
        @(negedge clk); rst = 1'b0;
        last_res = '0;
        run_op(3'd0, 1'b0, 16'h1234, 16'h1111, 1'b0, 0);
        chk("post_rst_sum", result, 16'h2345);

        for (int i = 0; i < 40; i++) begin
            run_op(3'($urandom_range(0, 7)), 1'($urandom), WIDTH'($urandom), WIDTH'($urandom),
                   1'($urandom), bit'($urandom_range(0, 3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_wide.md
ALU_WIDE -- requirements
Module: alu_wide

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits; legal values 8, 16, 24, 32.
REQ-002 SHALL define derived constant SLICES = WIDTH/8, the number of 8-bit slices processed.
REQ-003 SHALL have one clock and an asynchronous, active-high reset. No other clock or reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 start  input  1  request; sampled only when busy=0.
REQ-007 op  input  3  operation: 0 SUM, 1 AND, 2 EOR, 3 OR, 4 SR, 5 ROR; 6 and 7 are reserved.
REQ-008 inv_b  input  1  invert B operand before use (SUM with inv_b gives subtraction).
REQ-009 a_in  input  WIDTH  operand A.
REQ-010 b_in  input  WIDTH  operand B.
REQ-011 carry_in  input  1  carry/borrow input and rotate-in bit.
REQ-012 busy  output  1  operation in progress.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 result  output  WIDTH  operation result.
REQ-015 carry_out  output  1  carry flag.
REQ-016 overflow_out  output  1  signed overflow flag.
REQ-017 zero_out  output  1  result == 0.
REQ-018 neg_out  output  1  result[WIDTH-1].

Function
REQ-019 The datapath SHALL be one 8-bit slice per cycle, with carry chained between slices in a register.
REQ-020 FSM states SHALL be IDLE, RUN and FINISH.
- IDLE->RUN on start.
- RUN->FINISH after SLICES slice cycles.
- FINISH->IDLE unconditionally.
REQ-021 On the edge where start is sampled with busy=0, the block SHALL:
- latch op, inv_b, a_in, b_in and carry_in;
- clear the slice counter;
- set busy=1.
REQ-022 start while busy=1 SHALL be ignored. Input changes after acceptance SHALL NOT affect the operation.
REQ-023 SUM, AND, EOR and OR SHALL process slices LSB-first. SR and ROR SHALL process slices MSB-first, passing the shifted-out bit down to the next slice.
REQ-024 inv_b SHALL apply bitwise NOT to B for SUM, AND, EOR and OR; it has no effect on SR or ROR.
REQ-025 SUM SHALL compute result = A + B' + carry_in modulo 2^WIDTH.
- carry_out = carry out of bit WIDTH-1.
- overflow_out = (A[W-1]==B'[W-1]) and (result[W-1]!=A[W-1]).
REQ-026 AND, EOR and OR SHALL be bitwise on A and B', with carry_out=carry_in and overflow_out=0.
REQ-027 SR SHALL give result = A>>1 with 0 into the MSB, carry_out = A[0], overflow_out = 0.
REQ-028 ROR SHALL give result = {carry_in, A[WIDTH-1:1]}, carry_out = A[0], overflow_out = 0.
REQ-029 Reserved ops SHALL give result = 0, carry_out = carry_in, overflow_out = 0, zero_out = 1, with normal latency.
REQ-030 zero_out and neg_out SHALL be derived from the final full-width result, for all ops.
REQ-031 Latency SHALL be fixed: with start sampled at edge E, done=1 for exactly one cycle following edge E+SLICES+1.
REQ-032 busy SHALL be 1 from edge E through the cycle before done, and 0 during the done cycle.
REQ-033 A start during the done cycle SHALL be accepted (back-to-back throughput of SLICES+1 cycles per op).
REQ-034 result and all flags SHALL update only at the edge that raises done, and SHALL hold until the next done. Partial slices SHALL never be visible on result.
REQ-035 WIDTH=8 SHALL behave identically to an 8-bit 6502-style ALU, with latency 2.

Reset
REQ-036 rst=1 SHALL asynchronously force:
- FSM to IDLE;
- busy=0, done=0;
- result=0;
- carry_out=0, overflow_out=0, neg_out=0;
- zero_out=1;
- all latched operands and the slice counter to 0.
REQ-037 Reset mid-operation SHALL abort the operation with no done pulse. The first start after rst falls SHALL be accepted normally.

Verification (WIDTH=16)
REQ-038 SUM, A=0x00FF, B=0x0001, cin=0 -> result=0x0100, carry=0, overflow=0, zero=0; done exactly 3 cycles after the start edge.
REQ-039 SUM, A=0x7FFF, B=0x0001, cin=0 -> result=0x8000, overflow=1, neg=1, carry=0. SUM, A=0xFFFF, B=0x0001, cin=0 -> result=0x0000, carry=1, zero=1.
REQ-040 SUM with inv_b=1, A=0x0000, B=0x0001, cin=1 -> result=0xFFFF, carry=0, neg=1. SUM with inv_b=1, A=0x000F, B=0x000C, cin=1 -> result=0x0003, carry=1.
REQ-041 Shift and rotate cases:
- SR, A=0xF001 -> result=0x7800, carry=1.
- ROR, A=0x0001, cin=1 -> result=0x8000, carry=1.
- EOR, A=0xF0F0, B=0xAAAA -> 0x5A5A.
REQ-042 Handshake case: start SUM; pulse start with different operands while busy -> ignored, first result unchanged. Start again in the done cycle -> accepted.
REQ-043 Reset case: assert rst one cycle into RUN -> outputs at reset values immediately, no done pulse. A subsequent SUM 0x1234+0x1111 -> result=0x2345.
